// File: rtl/rf_pkg.sv
// Shared types for the ping-pong operand register file: per-bank state
// and the aggregate fill-level encoding.
package rf_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        EMPTY2   = 2'd0,
        ONE_FULL = 2'd1,
        FULL2    = 2'd2
    } fill_level_e;

    // Number of banks currently holding a completed fill.
    function automatic fill_level_e fill_level_of(input bank_state_e b0, input bank_state_e b1);
        if (b0 == BANK_FULL && b1 == BANK_FULL) begin
            return FULL2;
        end else if (b0 == BANK_FULL || b1 == BANK_FULL) begin
            return ONE_FULL;
        end else begin
            return EMPTY2;
        end
    endfunction

endpackage

// File: rtl/rf_bank.sv
// One operand bank: DEPTH words with synchronous write and a registered
// read port. Callers only strobe we/re with in-range addresses.
module rf_bank
    import rf_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 2,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_BITWIDTH-1:0] waddr,
    input  logic [DATA_BITWIDTH-1:0] wdata,
    input  logic                     re,
    input  logic [ADDR_BITWIDTH-1:0] raddr,
    output logic [DATA_BITWIDTH-1:0] rdata
);

    logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];
    logic [DATA_BITWIDTH-1:0] rd_data_q;
    logic [DATA_BITWIDTH-1:0] rd_data_d;

    // Storage array write port.
    // NOTE: the array has no reset branch so it maps onto plain RAM/flops
    // without a reset tree; validity is tracked by the bank state instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds unless a read is strobed.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[raddr];
        end
    end

    // Registered read port, cleared on reset so r_data starts at zero.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/rf_iw_pingpong.sv
// Double-buffered activation/weight register file. Hardware tracks which
// bank is being filled and which is being consumed; a bank flips to FULL on
// its w_last beat and back to EMPTY on r_release.
module rf_iw_pingpong
    import rf_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 2,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     w_last,
    input  logic                     r_en,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    input  logic                     r_release,
    output logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     r_valid,
    output logic                     rd_bank_ready,
    output logic                     wr_bank,
    output logic                     rd_bank,
    output logic [1:0]               fill_level,
    output logic                     err_addr
);

    // One extra bit so DEPTH == 2**ADDR_BITWIDTH is representable.
    localparam logic [ADDR_BITWIDTH:0] DEPTH_LIM = (ADDR_BITWIDTH + 1)'(DEPTH);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        rd_sel_q, rd_sel_d;    // bank that produced the current r_data
    logic        rd_zero_q, rd_zero_d;  // current r_data came from an out-of-range read
    logic        r_valid_q, r_valid_d;
    logic        err_q, err_d;

    logic        w_acc, r_acc, rel;
    logic        w_in_range, r_in_range;
    logic [1:0]  bank_we, bank_re;
    logic [DATA_BITWIDTH-1:0] bank_rdata [2];

    for (genvar i = 0; i < 2; i++) begin : g_bank
        rf_bank #(
            .DATA_BITWIDTH (DATA_BITWIDTH),
            .ADDR_BITWIDTH (ADDR_BITWIDTH),
            .DEPTH         (DEPTH)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[i]),
            .waddr (w_addr),
            .wdata (w_data),
            .re    (bank_re[i]),
            .raddr (r_addr),
            .rdata (bank_rdata[i])
        );
    end

    // Controller state register; the partial fill is abandoned on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            rd_zero_q <= 1'b0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_sel_q  <= rd_sel_d;
            rd_zero_q <= rd_zero_d;
            r_valid_q <= r_valid_d;
            err_q     <= err_d;
        end
    end

    // Next state: fill completion and release hit different banks (write
    // bank is EMPTY, read bank is FULL), so both may apply in one cycle.
    always_comb begin
        bank_d    = bank_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_sel_d  = rd_sel_q;
        rd_zero_d = rd_zero_q;
        r_valid_d = r_acc;
        err_d     = err_q;
        if (w_acc && w_last) begin
            bank_d[wr_ptr_q] = BANK_FULL;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (rel) begin
            bank_d[rd_ptr_q] = BANK_EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
        end
        // A read samples the pre-release pointer even if released this cycle.
        if (r_acc) begin
            rd_sel_d  = rd_ptr_q;
            rd_zero_d = !r_in_range;
        end
        if ((w_acc && !w_in_range) || (r_acc && !r_in_range)) begin
            err_d = 1'b1;
        end
    end

    // Handshake qualifiers, bank strobes and output muxing from state.
    always_comb begin
        w_ready       = (bank_q[wr_ptr_q] == BANK_EMPTY);
        rd_bank_ready = (bank_q[rd_ptr_q] == BANK_FULL);
        w_in_range    = ({1'b0, w_addr} < DEPTH_LIM);
        r_in_range    = ({1'b0, r_addr} < DEPTH_LIM);
        w_acc         = w_valid && w_ready;
        r_acc         = r_en && rd_bank_ready;
        rel           = r_release && rd_bank_ready;
        bank_we       = '0;
        bank_re       = '0;
        // Out-of-range beats are accepted but never reach the array.
        bank_we[wr_ptr_q] = w_acc && w_in_range;
        bank_re[rd_ptr_q] = r_acc && r_in_range;
        r_data        = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
        r_valid       = r_valid_q;
        wr_bank       = wr_ptr_q;
        rd_bank       = rd_ptr_q;
        fill_level    = fill_level_of(bank_q[0], bank_q[1]);
        err_addr      = err_q;
    end

endmodule

// File: doc/rf_iw_pingpong.md
# rf_iw_pingpong

Parametrised double-buffered register file for activation/weight operands in the PE array. It sits between the global-buffer fill path and the MAC datapath. Bank swapping is automatic: hardware tracks per-bank full/empty state, so no external `write_sel` is needed. A valid/ready fill handshake and an explicit consumer release let the fill of one bank overlap MAC reads of the other without software sequencing.

## Interface
Parameters:
- `DATA_BITWIDTH`, 16, operand width
- `ADDR_BITWIDTH`, 2, bank address width
- `DEPTH`, 4, words per bank; must satisfy `DEPTH <= 2**ADDR_BITWIDTH`

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `w_valid`  in  1  fill word present
- `w_ready`  out  1  current write bank can accept
- `w_addr`  in  `ADDR_BITWIDTH`  fill address
- `w_data`  in  `DATA_BITWIDTH`  fill data
- `w_last`  in  1  qualifies final word of a bank fill
- `r_en`  in  1  read request
- `r_addr`  in  `ADDR_BITWIDTH`  read address
- `r_release`  in  1  consumer done with current read bank
- `r_data`  out  `DATA_BITWIDTH`  registered read data
- `r_valid`  out  1  `r_data` updated this cycle
- `rd_bank_ready`  out  1  read bank holds a completed fill
- `wr_bank`  out  1  index of bank being filled
- `rd_bank`  out  1  index of bank being read
- `fill_level`  out  2  number of full banks (0..2)
- `err_addr`  out  1  sticky: access with address >= `DEPTH`

## Operation
- State: `wr_ptr`, `rd_ptr` (1 bit each), `bank_full[1:0]`. Each bank has two states, EMPTY and FULL. The aggregate controller state is EMPTY2, ONE_FULL or FULL2, exposed as `fill_level`.
- `w_ready = !bank_full[wr_ptr]`.
- Write accept (`w_valid && w_ready`) stores `w_data` at `mem[wr_ptr][w_addr]`. If `w_last` is set on the accepted beat, then `bank_full[wr_ptr] <= 1` and `wr_ptr` toggles.
- `rd_bank_ready = bank_full[rd_ptr]`.
- `r_en` while `rd_bank_ready`: next cycle `r_data = mem[rd_ptr][r_addr]` and `r_valid = 1`.
- `r_en` while not ready: ignored. `r_valid = 0` and `r_data` holds.
- `r_release` while `rd_bank_ready`: `bank_full[rd_ptr] <= 0` and `rd_ptr` toggles. `r_release` while not ready is ignored.
- Same-cycle `r_en` + `r_release`: the read uses the pre-release `rd_ptr`, then the bank is released.
- Same-cycle fill completion (`w_last`) on one bank + release of the other: both take effect. `fill_level` is unchanged in that case.
- Write/read collision on the same bank is impossible: the write bank is EMPTY, the read bank is FULL. No bypass path is required.
- Out-of-range address (>= `DEPTH`):
  - On write: the data is dropped but the beat is still accepted, and `w_last` still completes the fill. `err_addr` is set.
  - On read: returns 0 with `r_valid = 1`. `err_addr` is set.
- `err_addr` clears only on reset.
- Memory contents are not reset. After reset, banks are logically empty.

## Timing
- Reset values: `w_ready = 1`, `r_data = 0`, `r_valid = 0`, `rd_bank_ready = 0`, `wr_bank = 0`, `rd_bank = 0`, `fill_level = 0`, `err_addr = 0`.
- Read latency is 1 cycle from the `r_en` edge to `r_data`/`r_valid`. `r_valid` is a one-cycle pulse per accepted `r_en`; back-to-back reads give one word per cycle.
- `w_ready` is combinational from state only, never from `w_valid`. It deasserts the cycle after the `w_last` beat that fills the second bank.
- `rd_bank_ready` rises the cycle after the `w_last` beat when the read bank was empty. Minimum fill-to-first-read gap is 1 cycle.
- Reset asserted mid-fill or mid-read: all state returns to reset values immediately (asynchronous). The partial fill is discarded. Any in-flight `r_valid` is cancelled.
- Throughput: with alternating fill/consume, fill and read streams both sustain 1 word/cycle.

## Structure
- Shared package `rf_pkg`: `BANK_EMPTY`/`BANK_FULL` encodings and the `fill_level` encodings (EMPTY2 = 0, ONE_FULL = 1, FULL2 = 2).
- Sub-module `rf_bank`: one `DEPTH`×`DATA_BITWIDTH` array with synchronous write and registered read. It is instantiated twice.
- The top level holds the pointers, the full flags, output muxing and error logic.

## Test plan
- Reset, then fill bank0 with 1,2,3,4 at addresses 0–3 (`w_last` on the 4th beat), then read addresses 3,0 → `r_data` = 4 then 1 on consecutive cycles; `rd_bank = 0`, `wr_bank = 1`, `fill_level = 1`.
- Fill both banks without any release → `w_ready = 0` the cycle after the second `w_last` and `fill_level = 2`. Further `w_valid` beats do not alter bank0 data; a re-read returns the original values.
- Same cycle: `r_release` of bank0 and `w_last` on bank1 → `fill_level` stays 1, `rd_bank = 1`, `wr_bank = 0`, `w_ready = 1`.
- `r_en` with `r_addr = 2` + `r_release` in the same cycle → next cycle `r_data` = bank0[2] = 3 and `rd_bank` toggles.
- `DEPTH = 3`, write to address 3 → data dropped, `err_addr = 1` sticky. A read of address 3 returns 0 with `r_valid = 1`.
- Assert `reset` low after 2 of 4 fill beats → all outputs at reset values immediately. A following full fill and read returns the new data only.
